// File: rtl/perceptron_trainer.sv
// Single-layer perceptron trainer: sequential MAC over stored samples, threshold decision,
// saturating error-driven weight updates, repeated by epoch until zero errors or the epoch limit.
module perceptron_trainer #(
  parameter int unsigned N_IN      = 2,
  parameter int unsigned N_SAMP    = 4,
  parameter int unsigned W         = 16,
  parameter int unsigned FRAC      = 8,
  parameter int unsigned ETA_SH    = 1,
  parameter int unsigned MAX_EPOCH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_samp_we,
  input  logic [$clog2(N_SAMP)-1:0]  i_samp_addr,
  input  logic [N_IN*W-1:0]          i_samp_x,
  input  logic                       i_samp_d,
  input  logic                       i_w_we,
  input  logic [$clog2(N_IN+1)-1:0]  i_w_addr,
  input  logic [W-1:0]               i_w_wdata,
  output logic [W-1:0]               o_w_rdata,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_converged,
  output logic [7:0]                 o_epochs,
  output logic [N_SAMP-1:0]          o_result
);

  localparam int unsigned SW = $clog2(N_SAMP);
  localparam int unsigned IW = $clog2(N_IN + 1);
  localparam int unsigned EW = $clog2(N_SAMP + 1);
  localparam int unsigned AW = 2 * W + IW + 1;
  localparam logic signed [W-1:0] BiasDelta = W'((32'd1 << FRAC) >> ETA_SH);

  typedef enum logic [2:0] {StIdle, StMac, StDecide, StUpdate, StNext, StDone} state_t;

  state_t                r_state, w_state_nxt;
  logic signed [W-1:0]   r_w  [N_IN+1];
  logic signed [W-1:0]   r_sx [N_SAMP][N_IN];
  logic [N_SAMP-1:0]     r_sd;
  logic signed [AW-1:0]  r_acc;
  logic [SW-1:0]         r_samp;
  logic [IW-1:0]         r_idx;
  logic [7:0]            r_epoch;
  logic [EW-1:0]         r_err;
  logic                  r_conv;
  logic [7:0]            r_epochs;
  logic [N_SAMP-1:0]     r_result;

  logic [IW-1:0]         w_xsel;
  logic signed [W-1:0]   w_x;
  logic signed [W-1:0]   w_wmul;
  logic signed [2*W-1:0] w_prod;
  logic signed [AW-1:0]  w_bias;
  logic signed [W-1:0]   w_delta;
  logic signed [W:0]     w_wext, w_dext, w_sum;
  logic signed [W-1:0]   w_upd;
  logic                  w_y;
  logic                  w_last_samp;

  // UPDATE step k uses input k-1; MAC step idx uses input idx
  assign w_xsel = (r_state == StUpdate) ? r_idx - IW'(1) : r_idx;

  always_comb begin
    w_x = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (w_xsel == IW'(i)) w_x = r_sx[r_samp][i];
    end
  end

  assign w_wmul  = r_w[r_idx + IW'(1)];
  assign w_prod  = w_wmul * w_x;
  assign w_bias  = {{(AW - W){r_w[0][W-1]}}, r_w[0]} << FRAC;
  assign w_delta = (r_idx == '0) ? BiasDelta : (w_x >>> ETA_SH);
  assign w_wext  = {r_w[r_idx][W-1], r_w[r_idx]};
  assign w_dext  = {w_delta[W-1], w_delta};
  assign w_sum   = r_sd[r_samp] ? (w_wext + w_dext) : (w_wext - w_dext);
  assign w_y     = ~r_acc[AW-1];
  assign w_last_samp = (r_samp == SW'(N_SAMP - 1));

  always_comb begin
    w_upd = w_sum[W-1:0];
    if (w_sum[W] != w_sum[W-1]) w_upd = w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:   if (i_start) w_state_nxt = StMac;
      StMac:    if (r_idx == IW'(N_IN - 1)) w_state_nxt = StDecide;
      StDecide: w_state_nxt = (w_y == r_sd[r_samp]) ? StNext : StUpdate;
      StUpdate: if (r_idx == IW'(N_IN)) w_state_nxt = StNext;
      StNext: begin
        if (!w_last_samp)                        w_state_nxt = StMac;
        else if (r_err == '0)                    w_state_nxt = StDone;
        else if (r_epoch == 8'(MAX_EPOCH - 1))   w_state_nxt = StDone;
        else                                     w_state_nxt = StMac;
      end
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k <= int'(N_IN); k++) r_w[k] <= '0;
      for (int s = 0; s < int'(N_SAMP); s++) begin
        for (int i = 0; i < int'(N_IN); i++) r_sx[s][i] <= '0;
      end
      r_sd     <= '0;
      r_acc    <= '0;
      r_samp   <= '0;
      r_idx    <= '0;
      r_epoch  <= '0;
      r_err    <= '0;
      r_conv   <= 1'b0;
      r_epochs <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_w_we && (i_w_addr <= IW'(N_IN))) r_w[i_w_addr] <= i_w_wdata;
          if (i_samp_we && (int'(i_samp_addr) < int'(N_SAMP))) begin
            for (int i = 0; i < int'(N_IN); i++) r_sx[i_samp_addr][i] <= i_samp_x[i*W +: W];
            r_sd[i_samp_addr] <= i_samp_d;
          end
          if (i_start) begin
            r_acc    <= w_bias;
            r_samp   <= '0;
            r_idx    <= '0;
            r_epoch  <= '0;
            r_err    <= '0;
            r_conv   <= 1'b0;
            r_epochs <= '0;
          end
        end
        StMac: begin
          r_acc <= r_acc + {{(AW - 2 * W){w_prod[2*W-1]}}, w_prod};
          r_idx <= (r_idx == IW'(N_IN - 1)) ? '0 : r_idx + IW'(1);
        end
        StDecide: begin
          r_result[r_samp] <= w_y;
          if (w_y != r_sd[r_samp]) r_err <= r_err + EW'(1);
        end
        StUpdate: begin
          r_w[r_idx] <= w_upd;
          r_idx      <= (r_idx == IW'(N_IN)) ? '0 : r_idx + IW'(1);
        end
        StNext: begin
          if (!w_last_samp) begin
            r_samp <= r_samp + SW'(1);
            r_acc  <= w_bias;
          end else begin
            r_epochs <= r_epoch + 8'd1;
            if (r_err == '0) begin
              r_conv <= 1'b1;
            end else if (r_epoch != 8'(MAX_EPOCH - 1)) begin
              r_epoch <= r_epoch + 8'd1;
              r_err   <= '0;
              r_samp  <= '0;
              r_acc   <= w_bias;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_w_rdata   = r_w[i_w_addr];
  assign o_busy      = (r_state != StIdle);
  assign o_done      = (r_state == StDone);
  assign o_converged = r_conv;
  assign o_epochs    = r_epochs;
  assign o_result    = r_result;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer: an arithmetic reference model predicts each run,
// a monitor checks the done-time outputs, and the stimulus side checks weights and reset.
module tb_perceptron_trainer;

  localparam int N_IN = 2, N_SAMP = 4, W = 16, FRAC = 8, ETA_SH = 1, MAX_EPOCH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, samp_we = 1'b0, samp_d = 1'b0, w_we = 1'b0;
  logic [1:0]  samp_addr = '0, w_addr = '0;
  logic [31:0] samp_x = '0;
  logic [15:0] w_wdata = '0, w_rdata;
  logic        busy, done, conv;
  logic [7:0]  epochs;
  logic [3:0]  result;

  perceptron_trainer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_samp_we(samp_we), .i_samp_addr(samp_addr),
    .i_samp_x(samp_x), .i_samp_d(samp_d), .i_w_we(w_we), .i_w_addr(w_addr),
    .i_w_wdata(w_wdata), .o_w_rdata(w_rdata), .o_busy(busy), .o_done(done),
    .o_converged(conv), .o_epochs(epochs), .o_result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int conv; int epochs; int result; int lat; } exp_t;
  exp_t sb_q[$];
  int   start_cyc = 0;
  int   n_checks = 0, n_fail = 0;

  int m_w [0:N_IN];
  int m_x [0:N_SAMP-1][0:N_IN-1];
  int m_d [0:N_SAMP-1];
  int m_res [0:N_SAMP-1];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k <= N_IN; k++) m_w[k] = 0;
    for (int s = 0; s < N_SAMP; s++) begin
      m_d[s] = 0;
      m_res[s] = 0;
      for (int i = 0; i < N_IN; i++) m_x[s][i] = 0;
    end
  endtask

  // Plain-arithmetic perceptron rule; also tallies the cycle cost of each sample.
  task automatic model_run(output exp_t e);
    int ep, errs, lat, y, delta, nw;
    longint acc;
    lat = 1;
    e.conv = 0;
    for (ep = 0; ep < MAX_EPOCH; ep++) begin
      errs = 0;
      for (int s = 0; s < N_SAMP; s++) begin
        acc = longint'(m_w[0]) * (longint'(1) << FRAC);
        for (int i = 0; i < N_IN; i++) acc += longint'(m_w[i+1]) * longint'(m_x[s][i]);
        y = (acc >= 0) ? 1 : 0;
        m_res[s] = y;
        if (y == m_d[s]) lat += N_IN + 2;
        else begin
          errs++;
          lat += 2 * N_IN + 3;
          for (int k = 0; k <= N_IN; k++) begin
            delta = (k == 0) ? ((1 << FRAC) >>> ETA_SH) : (m_x[s][k-1] >>> ETA_SH);
            nw = (m_d[s] != 0) ? m_w[k] + delta : m_w[k] - delta;
            if (nw > 32767) nw = 32767;
            if (nw < -32768) nw = -32768;
            m_w[k] = nw;
          end
        end
      end
      if (errs == 0) begin
        e.conv = 1;
        break;
      end
    end
    e.epochs = (e.conv != 0) ? ep + 1 : MAX_EPOCH;
    e.result = 0;
    for (int s = 0; s < N_SAMP; s++) e.result |= (m_res[s] << s);
    e.lat = lat;
  endtask

  task automatic write_w(input int k, input int val);
    @(negedge clk);
    w_we = 1'b1; w_addr = 2'(k); w_wdata = 16'(val);
    @(negedge clk);
    w_we = 1'b0;
    m_w[k] = val;
  endtask

  task automatic write_s(input int s, input int x0, input int x1, input int d);
    @(negedge clk);
    samp_we = 1'b1; samp_addr = 2'(s); samp_x = {16'(x1), 16'(x0)}; samp_d = d[0];
    @(negedge clk);
    samp_we = 1'b0;
    m_x[s][0] = x0; m_x[s][1] = x1; m_d[s] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_weights(input string tag);
    for (int k = 0; k <= N_IN; k++) begin
      w_addr = 2'(k);
      #1;
      check({tag, "_w"}, longint'(w_rdata), longint'(m_w[k] & 'hFFFF));
    end
  endtask

  // mode 0: plain run; 1: writes and start during busy; 2: peek weights after first UPDATE
  task automatic run_train(input int mode, input string tag);
    exp_t e;
    int n;
    model_run(e);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    if (mode == 1) begin
      repeat (2) @(negedge clk);
      w_we = 1'b1; w_addr = 2'd1; w_wdata = 16'h1234;
      samp_we = 1'b1; samp_addr = 2'd0; samp_x = 32'h7000_7000; samp_d = 1'b1;
      start = 1'b1;
      @(negedge clk);
      w_we = 1'b0; samp_we = 1'b0; start = 1'b0;
    end else if (mode == 2) begin
      repeat (6) @(negedge clk);
      w_addr = 2'd0;
      #1 check("sat_w0", longint'(w_rdata), 64'h8080);
      w_addr = 2'd1;
      #1 check("sat_w1", longint'(w_rdata), 64'h7FFF);
    end
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check({tag, "_timeout"}, 1, 0);
    @(negedge clk);
    check({tag, "_sb_drain"}, sb_q.size(), 0);
    check_weights(tag);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  logic prev_done = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (prev_done) check("done_pulse", done, 0);
      prev_done = done;
      if (done === 1'b1) begin
        if (sb_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sb_q.pop_front();
          check("converged", conv, e.conv);
          check("epochs", epochs, e.epochs);
          check("result", result, e.result);
          check("latency", cyc - start_cyc, e.lat);
        end
      end
    end
  end

  initial begin
    int xa, xb;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_conv", conv, 0);
    check("rst_epochs", epochs, 0);
    check("rst_result", result, 0);
    check_weights("rst");

    // OR gate from zero weights
    write_s(0, 0, 0, 0); write_s(1, 256, 0, 1); write_s(2, 0, 256, 1); write_s(3, 256, 256, 1);
    run_train(0, "or");
    check("or_conv", conv, 1);
    check("or_epochs", epochs, 4);
    check("or_result", result, 4'b1110);
    w_addr = 2'd0; #1 check("or_w0", w_rdata, 16'hFF80);
    w_addr = 2'd1; #1 check("or_w1", w_rdata, 16'h0080);
    w_addr = 2'd2; #1 check("or_w2", w_rdata, 16'h0080);

    // Pre-trained OR weights with writes/start attempted while busy
    run_train(1, "pre");
    check("pre_epochs", epochs, 1);

    // XOR never converges
    write_s(0, 0, 0, 0); write_s(1, 256, 0, 1); write_s(2, 0, 256, 1); write_s(3, 256, 256, 0);
    write_w(0, 0); write_w(1, 0); write_w(2, 0);
    run_train(0, "xor");
    check("xor_conv", conv, 0);
    check("xor_epochs", epochs, MAX_EPOCH);

    // Saturating update
    do_reset();
    write_w(0, -32768); write_w(1, 32752); write_w(2, 0);
    write_s(0, 256, 0, 1);
    run_train(2, "sat");

    // Randomized runs
    for (int r = 0; r < 10; r++) begin
      for (int s = 0; s < N_SAMP; s++) begin
        xa = int'($urandom_range(1536)) - 768;
        xb = int'($urandom_range(1536)) - 768;
        write_s(s, xa, xb, int'($urandom_range(1)));
      end
      for (int k = 0; k <= N_IN; k++) begin
        if ($urandom_range(7) == 0) write_w(k, ($urandom_range(1) != 0) ? 32700 : -32700);
        else write_w(k, int'($urandom_range(4096)) - 2048);
      end
      run_train(int'($urandom_range(1)), "rnd");
    end

    // Reset in the middle of the first UPDATE
    do_reset();
    write_s(0, 0, 0, 0); write_s(1, 256, 0, 1); write_s(2, 0, 256, 1); write_s(3, 256, 256, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    check("midrst_epochs", epochs, 0);
    check_weights("midrst");

    // Reset wins over start and w_we in the same cycle
    @(negedge clk);
    rst = 1'b1; start = 1'b1; w_we = 1'b1; w_addr = 2'd1; w_wdata = 16'h5555;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; w_we = 1'b0;
    check("prio_busy", busy, 0);
    check("prio_w1", w_rdata, 16'h0000);
    @(negedge clk);
    check("prio_busy2", busy, 0);

    check("final_sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
